// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: one-entry sample buffer, self-generated BCLK/LRCLK, MSB-first
// 16-bit data in 32-bit slots with the standard one-BCLK delay after each LRCLK edge.
module i2s_tx #(
  parameter int unsigned BCLK_DIV   = 32,
  parameter int unsigned SLOT_WIDTH = 32
) (
  input  logic        audio_clk,
  input  logic        rst_in,
  input  logic        sample_valid_in,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  output logic        sample_ready_out,
  output logic        i2s_clk,
  output logic        lrcl_clk,
  output logic        sdata_out,
  output logic        frame_start_out,
  output logic        underrun_out
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_next;
  logic             full;
  logic [15:0]      hold_l;
  logic [15:0]      hold_r;
  logic [15:0]      left_sh;
  logic [15:0]      right_sh;
  logic             wrap;
  logic             fall;
  logic             boundary;
  logic             accept;
  logic             in_left;
  logic             in_right;

  always_comb begin
    wrap             = (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall             = wrap && i2s_clk;
    bit_next         = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);
    boundary         = fall && (bit_next == '0);
    in_left          = (bit_next >= CNT_W'(1)) && (bit_next <= CNT_W'(16));
    in_right         = (bit_next >= CNT_W'(SLOT_WIDTH + 1)) &&
                       (bit_next <= CNT_W'(SLOT_WIDTH + 16));
    sample_ready_out = !full && !rst_in;
    accept           = sample_valid_in && sample_ready_out;
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      div_cnt         <= '0;
      bit_cnt         <= '0;
      full            <= 1'b0;
      hold_l          <= '0;
      hold_r          <= '0;
      left_sh         <= '0;
      right_sh        <= '0;
      i2s_clk         <= 1'b0;
      lrcl_clk        <= 1'b0;
      sdata_out       <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      div_cnt         <= wrap ? '0 : div_cnt + DIV_W'(1);
      if (wrap) i2s_clk <= !i2s_clk;

      // Data and word select only move on BCLK falling edges.
      if (fall) begin
        bit_cnt   <= bit_next;
        lrcl_clk  <= (bit_next >= CNT_W'(SLOT_WIDTH));
        sdata_out <= 1'b0;
        if (boundary) begin
          frame_start_out <= 1'b1;
          underrun_out    <= !full;
          left_sh         <= full ? hold_l : '0;
          right_sh        <= full ? hold_r : '0;
        end else if (in_left) begin
          sdata_out <= left_sh[15];
          left_sh   <= {left_sh[14:0], 1'b0};
        end else if (in_right) begin
          sdata_out <= right_sh[15];
          right_sh  <= {right_sh[14:0], 1'b0};
        end
      end

      // accept needs !full, so it never collides with the load clearing full.
      if (boundary && full) begin
        full <= 1'b0;
      end else if (accept) begin
        full   <= 1'b1;
        hold_l <= left_in;
        hold_r <= right_in;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx: expected wire values are computed from absolute cycle time
// since reset and a per-frame table of transmitted samples.
module tb_i2s_tx;

  localparam int BCLK_DIV   = 32;
  localparam int SLOT_WIDTH = 32;
  localparam int P          = 2 * BCLK_DIV;      // BCLK period in audio_clk cycles
  localparam int F          = 2 * SLOT_WIDTH * P; // frame length in audio_clk cycles

  logic        audio_clk;
  logic        rst_in;
  logic        sample_valid_in;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        sample_ready_out;
  logic        i2s_clk;
  logic        lrcl_clk;
  logic        sdata_out;
  logic        frame_start_out;
  logic        underrun_out;

  i2s_tx #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_dut (
    .audio_clk       (audio_clk),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .left_in         (left_in),
    .right_in        (right_in),
    .sample_ready_out(sample_ready_out),
    .i2s_clk         (i2s_clk),
    .lrcl_clk        (lrcl_clk),
    .sdata_out       (sdata_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out)
  );

  initial audio_clk = 1'b0;
  always #5 audio_clk = ~audio_clk;

  int n_checks;
  int n_errors;

  // Reference model: cycle index since reset release, buffer, and per-frame payload table.
  int          t;
  bit          full_m;
  logic [15:0] hl;
  logic [15:0] hr;
  logic [15:0] fl[64];
  logic [15:0] fr[64];
  bit          fu[64];
  bit          last_acc;
  int          acc_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic exp_sdata(input int tt);
    int n, b, f;
    logic [15:0] w;
    n = tt / P;
    b = n % (2 * SLOT_WIDTH);
    f = n / (2 * SLOT_WIDTH);
    if (f > 63) return 1'b0;
    if (b >= 1 && b <= 16) begin
      w = fl[f];
      return w[16-b];
    end
    if (b >= SLOT_WIDTH + 1 && b <= SLOT_WIDTH + 16) begin
      w = fr[f];
      return w[SLOT_WIDTH+16-b];
    end
    return 1'b0;
  endfunction

  task automatic clear_model();
    t      = 0;
    full_m = 1'b0;
    for (int i = 0; i < 64; i++) begin
      fl[i] = '0;
      fr[i] = '0;
      fu[i] = 1'b0;
    end
  endtask

  // Check every output in the current cycle, then advance the model by one clock.
  task automatic tick();
    int  n, b, f, k;
    bit  rdy, fs;
    @(negedge audio_clk);
    n   = t / P;
    b   = n % (2 * SLOT_WIDTH);
    f   = t / F;
    rdy = !rst_in && !full_m;
    fs  = (t > 0) && (t % F == 0);
    check_eq("ready", {31'b0, sample_ready_out}, {31'b0, rdy});
    check_eq("bclk", {31'b0, i2s_clk}, (t / BCLK_DIV) % 2);
    check_eq("lrclk", {31'b0, lrcl_clk}, {31'b0, (b >= SLOT_WIDTH)});
    check_eq("sdata", {31'b0, sdata_out}, {31'b0, exp_sdata(t)});
    check_eq("frame_start", {31'b0, frame_start_out}, {31'b0, fs});
    check_eq("underrun", {31'b0, underrun_out}, {31'b0, fs && (f < 64) && fu[f]});
    last_acc = sample_valid_in && rdy;
    if (rst_in) begin
      clear_model();
      last_acc = 1'b0;
    end else begin
      if ((t + 1) % F == 0) begin
        k = (t + 1) / F;
        if (k < 64) begin
          fl[k] = full_m ? hl : 16'h0;
          fr[k] = full_m ? hr : 16'h0;
          fu[k] = !full_m;
        end
        full_m = 1'b0;
      end
      if (last_acc) begin
        full_m = 1'b1;
        hl     = left_in;
        hr     = right_in;
        acc_t  = t;
      end
      t++;
    end
    @(posedge audio_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int w;
    sample_valid_in = 1'b1;
    left_in         = l;
    right_in        = r;
    w               = 0;
    do begin
      tick();
      w++;
    end while (!last_acc && w < 2 * F);
    check_eq("send_accepted", {31'b0, last_acc}, 32'd1);
    sample_valid_in = 1'b0;
  endtask

  initial begin
    logic [15:0] x;
    int          w;
    n_checks        = 0;
    n_errors        = 0;
    acc_t           = 0;
    last_acc        = 1'b0;
    hl              = '0;
    hr              = '0;
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    left_in         = '0;
    right_in        = '0;
    clear_model();

    repeat (5) tick();
    rst_in = 1'b0;

    // Single sample, then hold valid with alternating data while the buffer is full.
    send(16'hA5C3, 16'h0F0F);
    x               = 16'($urandom);
    sample_valid_in = 1'b1;
    w               = 0;
    do begin
      left_in  = (w % 2 == 0) ? x : ~x;
      right_in = (w % 2 == 0) ? ~x : x;
      tick();
      w++;
    end while (!last_acc && w < 2 * F);
    sample_valid_in = 1'b0;
    check_eq("acc_after_load", acc_t, F);

    // Frame 3 boundary finds the buffer empty.
    while (t < 3 * F + 4) tick();

    // Ramp: every sample after the first is taken right after the previous load.
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 16'(i));
      if (i > 1) check_eq("ramp_gapless", acc_t % F, 0);
    end

    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 1500)) tick();
      send(16'($urandom), 16'($urandom));
    end

    // Fill the buffer early in a frame, then reset at bit 10.
    w = 0;
    while (((t % F) / P) != 2 && w < 2 * F) begin
      tick();
      w++;
    end
    send(16'($urandom), 16'($urandom));
    w = 0;
    while (((t % F) / P) != 10 && w < 2 * F) begin
      tick();
      w++;
    end
    check_eq("full_before_reset", {31'b0, full_m}, 32'd1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    repeat (F + 10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
